// File: rtl/alu_vector_checker_pkg.sv
// Shared types and constants for the ALU vector checker: FSM states,
// vector word layout and the named Hack ALU control codes.
package alu_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int ID_W = 8;
  localparam int OP_W = 6;

  // Hack ALU control words {zx,nx,zy,ny,f,no}
  localparam logic [OP_W-1:0] OP_ZERO   = 6'b101010;
  localparam logic [OP_W-1:0] OP_ONE    = 6'b111111;
  localparam logic [OP_W-1:0] OP_XPLUSY = 6'b000010;
  localparam logic [OP_W-1:0] OP_XANDY  = 6'b000000;

  // Vector word, MSB first: id, x, y, op, exp_out, exp_zr, exp_ng
  function automatic int vec_w(input int width);
    return 3 * width + 16;
  endfunction

  localparam int NG_LSB  = 0;
  localparam int ZR_LSB  = 1;
  localparam int EXP_LSB = 2;

  function automatic int op_lsb(input int width);
    return width + 2;
  endfunction

  function automatic int y_lsb(input int width);
    return width + 8;
  endfunction

  function automatic int x_lsb(input int width);
    return 2 * width + 8;
  endfunction

  function automatic int id_lsb(input int width);
    return 3 * width + 8;
  endfunction

endpackage

// File: rtl/alu_vector_checker_if.sv
// Bus between the checker, its vector ROM and the ALU under test.
// The ROM is a synchronous read: rom_data belongs to the rom_addr presented
// one cycle earlier. The ALU is purely combinational on alu_x/alu_y/alu_op.
interface alu_vector_checker_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
);
  import alu_test_pkg::*;

  localparam int VEC_W = vec_w(WIDTH);

  logic [ADDR_W-1:0] rom_addr;
  logic [VEC_W-1:0]  rom_data;
  logic [WIDTH-1:0]  alu_x;
  logic [WIDTH-1:0]  alu_y;
  logic [OP_W-1:0]   alu_op;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zr;
  logic              alu_ng;

  modport master (
    output rom_addr, alu_x, alu_y, alu_op,
    input  rom_data, alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  rom_addr, alu_x, alu_y, alu_op,
    output rom_data, alu_out, alu_zr, alu_ng
  );

endinterface

// File: rtl/alu_vec_compare.sv
// Field-wise comparison of actual ALU results against the expected ones.
module alu_vec_compare #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] act_out,
  input  logic             act_zr,
  input  logic             act_ng,
  input  logic [WIDTH-1:0] exp_out,
  input  logic             exp_zr,
  input  logic             exp_ng,
  output logic [2:0]       match
);

  // {out_ok, zr_ok, ng_ok}
  always_comb begin
    match = {act_out == exp_out, act_zr == exp_zr, act_ng == exp_ng};
  end

endmodule

// File: rtl/alu_vector_checker.sv
// Walks a vector ROM, drives each vector into the ALU under test and checks
// its results, three cycles per vector (FETCH, LOAD, CHECK).
//
// Handshake: start is a level sampled only in IDLE or DONE (ignored while
// busy). res_valid is a one-cycle pulse during CHECK with no back-pressure;
// res_id and res_match are meaningful only while res_valid is high.
module alu_vector_checker
  import alu_test_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 36,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop_on_fail,
  alu_vector_checker_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [2:0]           res_match,
  output logic [ADDR_W:0]      pass_count,
  output logic [ADDR_W:0]      fail_count,
  output logic [ID_W-1:0]      first_fail_id,
  output logic                 first_fail_valid,
  output state_t               state_dbg
);

  localparam int X_LSB  = x_lsb(WIDTH);
  localparam int Y_LSB  = y_lsb(WIDTH);
  localparam int OP_LSB = op_lsb(WIDTH);
  localparam int ID_LSB = id_lsb(WIDTH);

  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              sof_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  exp_out_q;
  logic              exp_zr_q;
  logic              exp_ng_q;
  logic [2:0]        match;
  logic              vec_pass;
  logic              end_run;

  alu_vec_compare #(.WIDTH(WIDTH)) u_compare (
    .act_out (bus.alu_out),
    .act_zr  (bus.alu_zr),
    .act_ng  (bus.alu_ng),
    .exp_out (exp_out_q),
    .exp_zr  (exp_zr_q),
    .exp_ng  (exp_ng_q),
    .match   (match)
  );

  // A run ends on the last vector, or on the first failure when stopping early
  always_comb begin
    vec_pass = &match;
    end_run  = (ptr_q == PTR_LAST) || (!vec_pass && sof_q);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_LOAD;
      S_LOAD:         state_d = S_CHECK;
      S_CHECK:        state_d = end_run ? S_DONE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Status and result outputs decoded from the current state
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    res_valid = 1'b0;
    res_match = 3'b000;
    res_id    = id_q;
    state_dbg = state_q;
    case (state_q)
      S_FETCH, S_LOAD: busy = 1'b1;
      S_CHECK: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_match = match;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Vector pointer, operand registers, counters and first-fail record
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q            <= '0;
      sof_q            <= 1'b0;
      id_q             <= '0;
      exp_out_q        <= '0;
      exp_zr_q         <= 1'b0;
      exp_ng_q         <= 1'b0;
      bus.rom_addr     <= '0;
      bus.alu_x        <= '0;
      bus.alu_y        <= '0;
      bus.alu_op       <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_id    <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            ptr_q            <= '0;
            bus.rom_addr     <= '0;
            sof_q            <= stop_on_fail;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_id    <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          id_q       <= bus.rom_data[ID_LSB +: ID_W];
          bus.alu_x  <= bus.rom_data[X_LSB +: WIDTH];
          bus.alu_y  <= bus.rom_data[Y_LSB +: WIDTH];
          bus.alu_op <= bus.rom_data[OP_LSB +: OP_W];
          exp_out_q  <= bus.rom_data[EXP_LSB +: WIDTH];
          exp_zr_q   <= bus.rom_data[ZR_LSB];
          exp_ng_q   <= bus.rom_data[NG_LSB];
        end
        S_CHECK: begin
          if (vec_pass) begin
            pass_count <= pass_count + CNT_ONE;
          end else begin
            fail_count <= fail_count + CNT_ONE;
            if (!first_fail_valid) begin
              first_fail_id    <= id_q;
              first_fail_valid <= 1'b1;
            end
          end
          // rom_addr follows the pointer so FETCH presents it directly
          if (!end_run) begin
            ptr_q        <= ptr_q + PTR_ONE;
            bus.rom_addr <= ptr_q + PTR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: a 36-vector instance (a) and a 4-vector
// instance (b), each with a synchronous ROM and a Hack ALU model.
module tb_alu_vector_checker;
  import alu_test_pkg::*;

  localparam int W = 16;
  localparam int AW = 6;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   op;
    logic [W-1:0] exp_out;
    logic         exp_zr;
    logic         exp_ng;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, start_a, sof_a, busy_a, done_a, rv_a, ffv_a;
  logic reset_b, start_b, sof_b, busy_b, done_b, rv_b, ffv_b;
  logic [7:0] rid_a, ffid_a, rid_b, ffid_b;
  logic [2:0] rm_a, rm_b;
  logic [AW:0] pc_a, fc_a, pc_b, fc_b;
  state_t st_a, st_b;

  alu_vector_checker_if #(.WIDTH(W), .ADDR_W(AW)) bus_a ();
  alu_vector_checker_if #(.WIDTH(W), .ADDR_W(AW)) bus_b ();

  alu_vector_checker #(.WIDTH(W), .DEPTH(36), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset_a), .start(start_a), .stop_on_fail(sof_a),
    .bus(bus_a), .busy(busy_a), .done(done_a), .res_valid(rv_a),
    .res_id(rid_a), .res_match(rm_a), .pass_count(pc_a), .fail_count(fc_a),
    .first_fail_id(ffid_a), .first_fail_valid(ffv_a), .state_dbg(st_a)
  );

  alu_vector_checker #(.WIDTH(W), .DEPTH(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .reset(reset_b), .start(start_b), .stop_on_fail(sof_b),
    .bus(bus_b), .busy(busy_b), .done(done_b), .res_valid(rv_b),
    .res_id(rid_b), .res_match(rm_b), .pass_count(pc_b), .fail_count(fc_b),
    .first_fail_id(ffid_b), .first_fail_valid(ffv_b), .state_dbg(st_b)
  );

  // ---------------- ROMs and ALU model ----------------
  logic [63:0] rom_a [64];
  logic [63:0] rom_b [64];

  always @(posedge clk) begin
    bus_a.rom_data <= rom_a[bus_a.rom_addr];
    bus_b.rom_data <= rom_b[bus_b.rom_addr];
  end

  function automatic logic [W+1:0] hack(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [5:0] op);
    logic [W-1:0] a, b, o;
    a = op[5] ? '0 : x;
    a = op[4] ? ~a : a;
    b = op[3] ? '0 : y;
    b = op[2] ? ~b : b;
    o = op[1] ? a + b : a & b;
    o = op[0] ? ~o : o;
    return {o, o == '0, o[W-1]};
  endfunction

  always_comb {bus_a.alu_out, bus_a.alu_zr, bus_a.alu_ng} = hack(bus_a.alu_x, bus_a.alu_y, bus_a.alu_op);
  always_comb {bus_b.alu_out, bus_b.alu_zr, bus_b.alu_ng} = hack(bus_b.alu_x, bus_b.alu_y, bus_b.alu_op);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];
  logic [AW-1:0] max_addr_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (rv_a) begin
      if (exp_q_a.size() == 0) begin
        n_checks++;
        $display("FAIL res_a_unexpected: got id %0h match %0b expected no result", rid_a, rm_a);
      end else begin
        e = exp_q_a.pop_front();
        check("res_a", {21'b0, rid_a, rm_a}, {21'b0, e});
      end
    end
    if (rv_b) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        $display("FAIL res_b_unexpected: got id %0h match %0b expected no result", rid_b, rm_b);
      end else begin
        e = exp_q_b.pop_front();
        check("res_b", {21'b0, rid_b, rm_b}, {21'b0, e});
      end
    end
    if (busy_b && bus_b.rom_addr > max_addr_b) max_addr_b = bus_b.rom_addr;
  end

  // ---------------- driver tasks ----------------
  vec_t tbl [10];
  logic busy_snap, pass_snap_ok;
  logic [AW-1:0] addr_snap;
  logic [AW:0] pass_snap;

  function automatic logic [63:0] mkword(input int id, input vec_t v);
    return {8'(id), v.x, v.y, v.op, v.exp_out, v.exp_zr, v.exp_ng};
  endfunction

  task automatic load_a();
    for (int i = 0; i < 36; i++) rom_a[i] = mkword(i, tbl[i % 10]);
  endtask

  task automatic push_a(input int first, input int count);
    for (int i = first; i < first + count; i++) exp_q_a.push_back({8'(i), 3'b111});
  endtask

  // Start a run at a negedge; n counts cycles from start acceptance to DONE.
  task automatic run(input bit sel, input bit sof, input int pulse_at, output int n);
    n = 0;
    if (sel) begin start_b = 1'b1; sof_b = sof; end
    else     begin start_a = 1'b1; sof_a = sof; end
    while (n < 1000) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (n == pulse_at) begin
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
      end
      if (n == 0) begin
        busy_snap = sel ? busy_b : busy_a;
        addr_snap = sel ? bus_b.rom_addr : bus_a.rom_addr;
      end
      if (n == 3) pass_snap = sel ? pc_b : pc_a;
      if (sel ? done_b : done_a) break;
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      $display("FAIL run_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    tbl[0] = '{16'h0005, 16'h0003, OP_XPLUSY, 16'h0008, 1'b0, 1'b0};
    tbl[1] = '{16'h1234, 16'h5678, OP_ZERO,   16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0042, 16'h0099, OP_ONE,    16'h0001, 1'b0, 1'b0};
    tbl[3] = '{16'h00F0, 16'h0FF0, OP_XANDY,  16'h00F0, 1'b0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, OP_XPLUSY, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0001, OP_XPLUSY, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h0011, 16'h0022, 6'b111010, 16'hFFFF, 1'b0, 1'b1};
    tbl[7] = '{16'h1234, 16'h0F0F, 6'b001100, 16'h1234, 1'b0, 1'b0};
    tbl[8] = '{16'h000A, 16'h0003, 6'b010011, 16'h0007, 1'b0, 1'b0};
    tbl[9] = '{16'h0005, 16'h0003, 6'b000111, 16'hFFFE, 1'b0, 1'b1};
    for (int i = 0; i < 64; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
    load_a();

    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0; sof_a = 1'b0; sof_b = 1'b0;
    max_addr_b = '0;
    repeat (3) @(negedge clk);

    // Reset state, and reset winning over start in the same cycle
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("rst_state", 32'(st_a), 32'(S_IDLE));
    check("rst_flags", {28'b0, busy_a, done_a, rv_a, ffv_a}, 32'h0);
    check("rst_counts", {18'b0, pc_a, fc_a}, 32'h0);
    check("rst_bus", {bus_a.alu_x, bus_a.alu_y}, 32'h0);
    check("rst_addr_op", {20'b0, bus_a.rom_addr, bus_a.alu_op}, 32'h0);
    check("rst_res", {21'b0, rid_a, rm_a}, 32'h0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);

    // Full passing run: 108 cycles, 36 passes
    push_a(0, 36);
    run(1'b0, 1'b0, -1, n);
    check("full_cycles", n, 108);
    check("full_busy_at_accept", {31'b0, busy_snap}, 1);
    check("full_first_addr", {26'b0, addr_snap}, 0);
    check("first_vec_pass_count", {25'b0, pass_snap}, 1);
    check("full_pass", {25'b0, pc_a}, 36);
    check("full_fail", {25'b0, fc_a}, 0);
    check("full_ffv", {31'b0, ffv_a}, 0);
    check("full_queue_empty", exp_q_a.size(), 0);
    repeat (5) @(negedge clk);
    check("done_hold", {24'b0, done_a, pc_a}, {24'b0, 1'b1, 7'd36});

    // start pulsed mid-run is ignored
    push_a(0, 36);
    run(1'b0, 1'b0, 20, n);
    check("midstart_cycles", n, 108);
    check("midstart_totals", {18'b0, pc_a, fc_a}, {18'b0, 7'd36, 7'd0});
    check("midstart_queue_empty", exp_q_a.size(), 0);

    // Two failing vectors, no early stop: first-fail record keeps id 1
    rom_a[1] = {8'd1, 16'h1234, 16'h5678, OP_ZERO, 16'h0000, 1'b0, 1'b0};
    rom_a[5] = {8'd5, 16'hFFFF, 16'h0001, OP_XPLUSY, 16'h0001, 1'b1, 1'b0};
    push_a(0, 1);
    exp_q_a.push_back({8'd1, 3'b101});
    push_a(2, 3);
    exp_q_a.push_back({8'd5, 3'b011});
    push_a(6, 30);
    run(1'b0, 1'b0, -1, n);
    check("fail_cycles", n, 108);
    check("fail_pass", {25'b0, pc_a}, 34);
    check("fail_fail", {25'b0, fc_a}, 2);
    check("fail_first_id", {24'b0, ffid_a}, 1);
    check("fail_ffv", {31'b0, ffv_a}, 1);
    check("fail_queue_empty", exp_q_a.size(), 0);
    load_a();

    // DEPTH=4, vector 1 fails, stop_on_fail
    rom_b[0] = mkword(0, tbl[0]);
    rom_b[1] = {8'd1, 16'h0042, 16'h0099, OP_ONE, 16'h0002, 1'b0, 1'b0};
    rom_b[2] = mkword(2, tbl[4]);
    rom_b[3] = mkword(3, tbl[6]);
    exp_q_b.push_back({8'd0, 3'b111});
    exp_q_b.push_back({8'd1, 3'b011});
    max_addr_b = '0;
    run(1'b1, 1'b1, -1, n);
    check("stop_cycles", n, 6);
    check("stop_totals", {18'b0, pc_b, fc_b}, {18'b0, 7'd1, 7'd1});
    check("stop_first_id", {23'b0, ffv_b, ffid_b}, {23'b0, 1'b1, 8'd1});
    check("stop_max_addr", {26'b0, max_addr_b}, 1);
    check("stop_queue_empty", exp_q_b.size(), 0);

    // Same ROM without early stop; restarting from DONE
    exp_q_b.push_back({8'd0, 3'b111});
    exp_q_b.push_back({8'd1, 3'b011});
    exp_q_b.push_back({8'd2, 3'b111});
    exp_q_b.push_back({8'd3, 3'b111});
    run(1'b1, 1'b0, -1, n);
    check("nostop_cycles", n, 12);
    check("nostop_totals", {18'b0, pc_b, fc_b}, {18'b0, 7'd3, 7'd1});
    check("nostop_queue_empty", exp_q_b.size(), 0);

    // Reset during the second CHECK aborts the run
    push_a(0, 2);
    start_a = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (st_a == S_CHECK) n++;
    end
    check("abort_reached_check2", n, 2);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    check("abort_state", 32'(st_a), 32'(S_IDLE));
    check("abort_flags", {28'b0, busy_a, done_a, rv_a, ffv_a}, 32'h0);
    check("abort_counts", {18'b0, pc_a, fc_a}, 32'h0);
    check("abort_bus", {bus_a.alu_x, bus_a.alu_y}, 32'h0);
    check("abort_addr_op", {20'b0, bus_a.rom_addr, bus_a.alu_op}, 32'h0);
    check("abort_res", {13'b0, rid_a, rm_a, ffid_a}, 32'h0);
    check("abort_queue_empty", exp_q_a.size(), 0);

    // Rerun after abort starts from address 0
    push_a(0, 36);
    run(1'b0, 1'b0, -1, n);
    check("rerun_first_addr", {26'b0, addr_snap}, 0);
    check("rerun_cycles", n, 108);
    check("rerun_totals", {18'b0, pc_a, fc_a}, {18'b0, 7'd36, 7'd0});
    check("rerun_queue_empty", exp_q_a.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_vector_checker.md
ALU_VECTOR_CHECKER -- requirements
Module: alu_vector_checker

Interface
REQ-001 Parameter WIDTH, default 16, ALU data width in bits (legal 8..32).
REQ-002 Parameter DEPTH, default 36, number of vectors in the vector ROM (legal 1..2**ADDR_W).
REQ-003 Parameter ADDR_W, default 6, vector ROM address width.
REQ-004 Derived constant VEC_W = 3*WIDTH + 16; vector fields MSB-first: id[8], x[WIDTH], y[WIDTH], op[6], exp_out[WIDTH], exp_zr[1], exp_ng[1].
REQ-005 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-006 Port reset, input, 1; reset is synchronous and active-high.
REQ-007 Port start, input, 1, begin a run when the checker is in IDLE or DONE.
REQ-008 Port stop_on_fail, input, 1, sampled at start; end the run at the first mismatching vector.
REQ-009 Port rom_addr, output, ADDR_W, vector ROM read address.
REQ-010 Port rom_data, input, VEC_W, vector word; valid one cycle after rom_addr is presented.
REQ-011 Port alu_x / alu_y, output, WIDTH each, registered ALU operands.
REQ-012 Port alu_op, output, 6, registered ALU control {zx,nx,zy,ny,f,no}.
REQ-013 Port alu_out / alu_zr / alu_ng, input, WIDTH/1/1, combinational ALU results.
REQ-014 Port busy, output, 1, high from start acceptance until DONE.
REQ-015 Port done, output, 1, high while in DONE.
REQ-016 Port res_valid, output, 1, one-cycle pulse per checked vector.
REQ-017 Port res_id, output, 8, id of the vector reported with res_valid.
REQ-018 Port res_match, output, 3, {out_ok, zr_ok, ng_ok} for the reported vector.
REQ-019 Port pass_count / fail_count, output, ADDR_W+1 each, running totals.
REQ-020 Port first_fail_id, output, 8; first_fail_valid, output, 1: id of the first failing vector in the run.

Function
REQ-021 States: IDLE, FETCH, LOAD, CHECK, DONE.
REQ-022 IDLE/DONE + start: clear counters, first_fail_valid, pointer=0, latch stop_on_fail, go to FETCH.
REQ-023 start while busy shall be ignored.
REQ-024 FETCH: rom_addr = pointer; next state LOAD.
REQ-025 LOAD: register rom_data fields; drive alu_x, alu_y, alu_op from them; next state CHECK.
REQ-026 CHECK: compare alu_out/zr/ng against expected fields; pulse res_valid with res_id and res_match.
REQ-027 CHECK, vector passes (all three ok): increment pass_count; otherwise increment fail_count.
REQ-028 CHECK, first fail of the run: capture first_fail_id, set first_fail_valid; later fails leave it unchanged.
REQ-029 CHECK exit: to DONE if pointer == DEPTH-1, or if the vector failed and latched stop_on_fail=1; otherwise pointer+1 and go to FETCH.
REQ-030 Throughput is exactly 3 cycles per vector; a full run takes 3*DEPTH cycles from start acceptance to DONE entry.
REQ-031 DONE holds all counters and the first-fail record until the next start or reset.
REQ-032 Counters never wrap: DEPTH <= 2**ADDR_W guarantees pass_count + fail_count <= DEPTH.
REQ-033 DEPTH=1: a single FETCH/LOAD/CHECK, then DONE.

Reset
REQ-034 Reset takes priority over start in the same cycle.
REQ-035 Reset shall force IDLE; busy, done and res_valid = 0; counters = 0; first_fail_valid = 0; first_fail_id = 0.
REQ-036 Reset shall also set rom_addr, alu_x, alu_y, alu_op, res_id and res_match = 0.
REQ-037 Reset mid-run shall abort the run, with no res_valid pulse in the following cycle.

Structure
REQ-038 Package alu_test_pkg shall hold the state enum, the VEC_W function, field offset constants and named Hack op constants (ZERO=6'b101010, ONE=6'b111111, XPLUSY=6'b000010, XANDY=6'b000000).
REQ-039 Sub-module alu_vec_compare (combinational, WIDTH-parametrised) shall produce res_match from the actual and expected results.

Verification
REQ-040 Vector x=0005, y=0003, op=000010, exp 0008/zr0/ng0 -> res_match=111; pass_count=1.
REQ-041 Vector op=101010, exp 0000/zr1/ng0 -> match=111; the same vector with exp_zr=0 -> match=101, fail_count=1, first_fail_id=its id.
REQ-042 DEPTH=4, vector 1 failing, stop_on_fail=1 -> DONE after 6 cycles; pass=1, fail=1; rom_addr never reaches 2.
REQ-043 DEPTH=36, all vectors passing -> DONE 108 cycles after start; pass=36, fail=0, first_fail_valid=0.
REQ-044 Reset asserted in the 2nd CHECK -> next cycle IDLE with all outputs 0; a subsequent start reruns from address 0.
REQ-045 start pulsed during the run -> ignored; the run completes with unchanged totals.
